adder_accum: RTL and testbench

ADDER_ACCUM -- requirements
Module: adder_accum

---
 rtl/adder_pkg.sv | 13 +
 rtl/adder_core.sv | 35 +++
 rtl/adder_accum.sv | 120 ++++++++++++
 tb/tb_adder_accum.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - mode encoding and default width for the adder/accumulator
package adder_pkg;

    localparam int ADDER_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_CLR = 2'b11
    } mode_e;

endpackage

// File: rtl/adder_core.sv
// rtl/adder_core.sv - combinational WIDTH-bit add/subtract with carry/borrow and signed overflow
module adder_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             ovf_o
);

    logic [WIDTH:0] ext;

    // The extra top bit is the carry for add and the borrow for subtract.
    always_comb begin
        if (sub_i) begin
            ext = {1'b0, a_i} - {1'b0, b_i};
        end else begin
            ext = {1'b0, a_i} + {1'b0, b_i};
        end
    end

    assign res_o   = ext[WIDTH-1:0];
    assign carry_o = ext[WIDTH];

    always_comb begin
        if (sub_i) begin
            ovf_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res_o[WIDTH-1] != a_i[WIDTH-1]);
        end else begin
            ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res_o[WIDTH-1] != a_i[WIDTH-1]);
        end
    end

endmodule

// File: rtl/adder_accum.sv
// rtl/adder_accum.sv - handshaked add/sub/accumulate unit; ADDER_ACCUM_SAT_EN enables unsigned saturation
module adder_accum #(
    parameter int WIDTH = adder_pkg::ADDER_DEFAULT_WIDTH
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum,
    output logic             carry_o,
    output logic             ovf_o,
    output logic [WIDTH-1:0] acc_o
);

    import adder_pkg::*;

    mode_e            mode;
    logic             accept;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH-1:0] core_a, core_b, core_res;
    logic             core_sub, core_carry, core_ovf;

    assign mode       = mode_e'(mode_i);
    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        core_a   = a_in;
        core_b   = b_in;
        core_sub = 1'b0;
        case (mode)
            MODE_SUB: core_sub = 1'b1;
            MODE_ACC: begin
                core_a = acc_q;
                core_b = a_in;
            end
            default: ;
        endcase
    end

    adder_core #(.WIDTH(WIDTH)) u_core (
        .a_i     (core_a),
        .b_i     (core_b),
        .sub_i   (core_sub),
        .res_o   (core_res),
        .carry_o (core_carry),
        .ovf_o   (core_ovf)
    );

    always_comb begin
        sum_d   = core_res;
        carry_d = core_carry;
        ovf_d   = core_ovf;
`ifdef ADDER_ACCUM_SAT_EN
        // Flags keep reporting the raw operation; only the value is clamped.
        if (core_carry) begin
            if (mode == MODE_SUB) begin
                sum_d = '0;
            end else if (mode != MODE_CLR) begin
                sum_d = {WIDTH{1'b1}};
            end
        end
`endif
        acc_d = acc_q;
        case (mode)
            MODE_ACC: acc_d = sum_d;
            MODE_CLR: begin
                sum_d   = '0;
                carry_d = 1'b0;
                ovf_d   = 1'b0;
                acc_d   = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                sum_q   <= sum_d;
                carry_q <= carry_d;
                ovf_q   <= ovf_d;
                acc_q   <= acc_d;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign sum         = sum_q;
    assign carry_o     = carry_q;
    assign ovf_o       = ovf_q;
    assign acc_o       = acc_q;

endmodule

// File: tb/tb_adder_accum.sv
// tb/tb_adder_accum.sv - directed self-checking bench for adder_accum at WIDTH=8
module tb_adder_accum;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    logic [W-1:0] acc;

    int n_cmp  = 0;
    int n_fail = 0;

    adder_accum #(.WIDTH(W)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mode_i      (mode),
        .a_in        (a),
        .b_in        (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .sum         (sum),
        .carry_o     (carry),
        .ovf_o       (ovf),
        .acc_o       (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv);
        in_valid = v;
        mode     = m;
        a        = av;
        b        = bv;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_sum",   sum, 0);
        check("rst_carry", carry, 0);
        check("rst_ovf",   ovf, 0);
        check("rst_acc",   acc, 0);
        check("rst_ready", in_ready, 1);

        @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_ready", in_ready, 1);

        drive(1'b1, 2'b00, 8'hF0, 8'h20);
        step();
        check("add_valid", out_valid, 1);
`ifdef ADDER_ACCUM_SAT_EN
        check("add_sum", sum, 8'hFF);
`else
        check("add_sum", sum, 8'h10);
`endif
        check("add_carry", carry, 1);
        check("add_ovf", ovf, 0);

        drive(1'b1, 2'b01, 8'h05, 8'h07);
        step();
`ifdef ADDER_ACCUM_SAT_EN
        check("sub_sum", sum, 8'h00);
`else
        check("sub_sum", sum, 8'hFE);
`endif
        check("sub_borrow", carry, 1);
        check("sub_ovf", ovf, 0);
        check("sub_acc_kept", acc, 0);

        drive(1'b1, 2'b00, 8'h7F, 8'h01);
        step();
        check("sovf_sum", sum, 8'h80);
        check("sovf_ovf", ovf, 1);
        check("sovf_carry", carry, 0);

        drive(1'b1, 2'b11, 8'hAA, 8'h55);
        step();
        check("clr_sum", sum, 0);
        check("clr_acc", acc, 0);
        check("clr_carry", carry, 0);
        check("clr_ovf", ovf, 0);

        drive(1'b1, 2'b10, 8'h10, 8'hEE);
        step();
        check("acc1_sum", sum, 8'h10);
        check("acc1_valid", out_valid, 1);
        drive(1'b1, 2'b10, 8'h20, 8'hEE);
        step();
        check("acc2_sum", sum, 8'h30);
        check("acc2_valid", out_valid, 1);
        drive(1'b1, 2'b10, 8'h30, 8'hEE);
        step();
        check("acc3_sum", sum, 8'h60);
        check("acc3_valid", out_valid, 1);
        check("acc3_acc", acc, 8'h60);

        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();
        check("drain_valid", out_valid, 0);
        check("drain_sum", sum, 8'h60);

        out_ready = 1'b0;
        drive(1'b1, 2'b00, 8'h01, 8'h02);
        step();
        check("bp_first_sum", sum, 8'h03);
        check("bp_first_ready", in_ready, 0);
        drive(1'b1, 2'b00, 8'h10, 8'h10);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_sum", sum, 8'h03);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        step();
        check("bp_second_sum", sum, 8'h20);
        check("bp_second_acc", acc, 8'h60);

        drive(1'b1, 2'b10, 8'h40, 8'h00);
        step();
        check("acc40_sum", sum, 8'hA0);
        check("acc40_ovf", ovf, 1);
        check("acc40_carry", carry, 0);
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        out_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_acc", acc, 0);
        check("midrst_sum", sum, 0);
        check("midrst_ready", in_ready, 1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 2'b10, 8'h05, 8'h00);
        step();
        check("after_rst_sum", sum, 8'h05);
        check("after_rst_acc", acc, 8'h05);

        drive(1'b1, 2'b10, 8'hFF, 8'h00);
        step();
`ifdef ADDER_ACCUM_SAT_EN
        check("accwrap_sum", sum, 8'hFF);
`else
        check("accwrap_sum", sum, 8'h04);
`endif
        check("accwrap_carry", carry, 1);
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
